i2c_scl_sched: RTL and testbench
================================

Name: i2c_scl_sched

Overview:
- Bus-clock scheduler for the I2C master: selects the SCL rate (10/100/400 kHz) and sequences SCL through four quarter-phases.
- Emits one-cycle phase strobes that the byte/bit engine uses to change SDA and to sample SDA.
- Handles slave clock stretching and clean start/stop of the clock train.
- Sits between the system clock domain and the open-drain SCL pad driver.

Parameters:
- CLK_FREQUENCY, 50000000: system clock frequency in Hz.
- QCNT_10K, CLK_FREQUENCY/(4*10000): cycles per quarter-period at 10 kHz (1250 at default).
- QCNT_100K, CLK_FREQUENCY/(4*100000): cycles per quarter-period at 100 kHz (125).
- QCNT_400K, CLK_FREQUENCY/(4*400000): cycles per quarter-period at 400 kHz (31, truncated).
- STRETCH_MAX, 50000: stretch timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  run the SCL clock train
- speed_sel  in  2  rate select: 0=10k, 1=100k, 2=400k, 3=reserved (treated as 100k)
- scl_in  in  1  raw SCL pad level (asynchronous)
- scl_oe  out  1  1 = drive SCL low; 0 = release SCL
- tick_low_mid  out  1  pulse at mid-low; SDA may change
- tick_rise  out  1  pulse when SCL is released
- tick_high_mid  out  1  pulse at mid-high; sample SDA
- tick_fall  out  1  pulse when SCL is driven low (bit boundary)
- busy  out  1  clock train active
- speed_active  out  2  rate latched for the current train
- stretching  out  1  in Q2 with synchronized SCL low
- stretch_timeout  out  1  timeout pulse (tied 0 without the optional feature)

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset.
- Reset values: scl_oe=0, all tick_* outputs=0, busy=0, speed_active=2'd1, stretching=0, stretch_timeout=0. State=IDLE, quarter counter=0.
- Reset asserted mid-operation releases SCL on the next edge; no strobes are emitted.
- scl_in passes through a 2-flop synchronizer to give scl_sync.
- State machine:
  - IDLE: scl_oe=0, busy=0.
  - IDLE -> RUN when en=1 is sampled. On the next edge: latch speed_sel into speed_active, QCNT = QCNT_x for that rate, quarter=Q0, scl_oe=1, busy=1. No tick is emitted on this entry.
  - RUN: an 11-bit counter counts 0..QCNT-1. At wrap the quarter advances Q0->Q1->Q2->Q3->Q0.
  - Strobes are registered and pulse in the first cycle of the new quarter:
    - entering Q1: tick_low_mid
    - entering Q2: tick_rise, and scl_oe=0
    - entering Q3: tick_high_mid
    - entering Q0: tick_fall, and scl_oe=1
  - Q2 (stretch): the counter advances only on cycles with scl_sync=1. stretching=1 on cycles in Q2 with scl_sync=0. With no stretching, the 2-cycle synchronizer latency adds 2 cycles to Q2, so period = 4*QCNT+2 cycles.
  - End of Q3: if en=1, continue to Q0 with tick_fall. If en=0, go to IDLE with SCL left released, no tick_fall, and busy=0 on that edge.
- en is examined only at the end of Q3. Deasserting en earlier does not shorten the bit.
- speed_sel is ignored while busy. A new value takes effect only at the next IDLE->RUN.
- Tick pulses are mutually exclusive and exactly one cycle wide.

Optional Feature:
- Macro: I2C_SCL_STRETCH_TIMEOUT_EN.
- Defined:
  - A 16-bit counter counts consecutive stretching cycles and clears whenever scl_sync=1.
  - When the count reaches STRETCH_MAX: stretch_timeout pulses for 1 cycle, scl_oe=0, busy=0, state=IDLE, regardless of en.
  - The next train requires en to be sampled high from IDLE.
- Not defined: stretching is unbounded, no counter is built, and stretch_timeout is tied to 0.

Decomposition:
- Package i2c_pkg holds:
  - speed codes (SPD_10K=0, SPD_100K=1, SPD_400K=2)
  - state encoding (IDLE, RUN)
  - quarter encoding (Q0..Q3)
  - the qcnt_for(speed) lookup
- Sub-module: i2c_sync2, the 2-flop synchronizer, reused later for SDA.

Test Plan:
- Bench setup for all scenarios: scl_in = ~scl_oe loopback, CLK_FREQUENCY=50 MHz.
- speed_sel=1, en=1 from reset -> scl_oe=1 for 250 cycles; tick_low_mid at +125, tick_rise at +250, stretching=1 for 2 cycles, tick_high_mid at +377, tick_fall at +502; period 502 cycles.
- speed_sel=2 -> QCNT=31; period 126 cycles; speed_active=2.
- Force scl_in=0 for 1000 cycles after tick_rise -> stretching high for 1002 cycles; tick_high_mid delayed by 1000 cycles versus the unstretched case.
- Drop en during Q1 and toggle speed_sel to 0 -> Q2/Q3 complete, busy falls at end of Q3, scl_oe=0, no tick_fall, speed_active unchanged.
- Assert reset during Q2 -> next edge: all outputs at reset values; re-enabling en restarts a clean train at Q0.
- With I2C_SCL_STRETCH_TIMEOUT_EN and STRETCH_MAX=100, hold scl_in=0 -> stretch_timeout pulses after 100 stretching cycles, busy=0, SCL released.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master clocking blocks.
// Contents: speed codes, FSM state and quarter-phase encodings, and the
// quarter-period lookup qcnt_for() used by the SCL scheduler.
package i2c_pkg;

  localparam logic [1:0] SPD_10K  = 2'd0;
  localparam logic [1:0] SPD_100K = 2'd1;
  localparam logic [1:0] SPD_400K = 2'd2;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // Q0/Q1: SCL driven low, Q2/Q3: SCL released.
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_e;

  // Quarter-period length for a rate code; the reserved code runs at 100 kHz.
  function automatic logic [10:0] qcnt_for(input logic [1:0]  spd,
                                           input int unsigned q10k,
                                           input int unsigned q100k,
                                           input int unsigned q400k);
    logic [10:0] r;
    case (spd)
      SPD_10K:  r = 11'(q10k);
      SPD_400K: r = 11'(q400k);
      default:  r = 11'(q100k);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_scl_sched_if.sv
// Bus bundle between the byte/bit engine (master side) and the SCL scheduler
// (slave side).
//   en, speed_sel, scl_in       : into the scheduler
//   scl_oe, tick_*, busy,
//   speed_active, stretching,
//   stretch_timeout             : out of the scheduler
interface i2c_scl_sched_if;
  logic       en;
  logic [1:0] speed_sel;
  logic       scl_in;
  logic       scl_oe;
  logic       tick_low_mid;
  logic       tick_rise;
  logic       tick_high_mid;
  logic       tick_fall;
  logic       busy;
  logic [1:0] speed_active;
  logic       stretching;
  logic       stretch_timeout;

  modport master (
    output en, speed_sel, scl_in,
    input  scl_oe, tick_low_mid, tick_rise, tick_high_mid, tick_fall, busy,
           speed_active, stretching, stretch_timeout
  );

  modport slave (
    input  en, speed_sel, scl_in,
    output scl_oe, tick_low_mid, tick_rise, tick_high_mid, tick_fall, busy,
           speed_active, stretching, stretch_timeout
  );
endinterface

// File: rtl/i2c_sync2.sv
// Two-flop synchronizer for an asynchronous pad level (SCL now, SDA later).
//   clk, reset : system clock, synchronous active-high reset
//   d_i        : asynchronous input
//   q_o        : synchronized level, two cycles of latency
module i2c_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/i2c_scl_sched.sv
// SCL clock-train scheduler. Runs SCL through four quarter-phases at the
// latched rate, emits one-cycle phase strobes, and waits in Q2 while a slave
// stretches the clock.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : i2c_scl_sched_if.slave (en/speed_sel/scl_in in; scl_oe,
//                tick_*, busy, speed_active, stretching, stretch_timeout out)
// Build option I2C_SCL_STRETCH_TIMEOUT_EN: abort the train after STRETCH_MAX
// consecutive stretching cycles; without it stretching is unbounded and
// stretch_timeout stays 0.
module i2c_scl_sched
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY = 50000000,
  parameter int unsigned QCNT_10K      = CLK_FREQUENCY / (4 * 10000),
  parameter int unsigned QCNT_100K     = CLK_FREQUENCY / (4 * 100000),
  parameter int unsigned QCNT_400K     = CLK_FREQUENCY / (4 * 400000),
  parameter int unsigned STRETCH_MAX   = 50000
) (
  input logic            clk,
  input logic            reset,
  i2c_scl_sched_if.slave bus
);

  state_e      state_q;
  quarter_e    quarter_q;
  logic [10:0] cnt_q;
  logic [1:0]  speed_q;
  logic        scl_oe_q, busy_q, stretch_timeout_q;
  logic        tick_lm_q, tick_rise_q, tick_hm_q, tick_fall_q;

  logic        scl_sync;
  logic        stretching;
  logic        cnt_adv;
  logic        cnt_wrap;
  logic        timeout_hit;
  logic [10:0] qcnt;

  i2c_sync2 #(
    .ResetVal(1'b1)
  ) u_scl_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (bus.scl_in),
    .q_o  (scl_sync)
  );

  assign qcnt       = qcnt_for(speed_q, QCNT_10K, QCNT_100K, QCNT_400K);
  assign cnt_wrap   = (cnt_q == qcnt - 11'd1);
  assign stretching = (state_q == StRun) && (quarter_q == Q2) && !scl_sync;
  // Q2 only progresses once the released line is actually seen high.
  assign cnt_adv    = (quarter_q != Q2) || scl_sync;

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  logic [15:0] stretch_cnt_q;

  assign timeout_hit = stretching && (stretch_cnt_q == 16'(STRETCH_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset || !stretching || timeout_hit) begin
      stretch_cnt_q <= '0;
    end else begin
      stretch_cnt_q <= stretch_cnt_q + 16'd1;
    end
  end
`else
  // No limit in this build: the train waits on the slave indefinitely.
  assign timeout_hit = (STRETCH_MAX == 0) && 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      quarter_q         <= Q0;
      cnt_q             <= '0;
      speed_q           <= SPD_100K;
      scl_oe_q          <= 1'b0;
      busy_q            <= 1'b0;
      stretch_timeout_q <= 1'b0;
      tick_lm_q         <= 1'b0;
      tick_rise_q       <= 1'b0;
      tick_hm_q         <= 1'b0;
      tick_fall_q       <= 1'b0;
    end else begin
      tick_lm_q         <= 1'b0;
      tick_rise_q       <= 1'b0;
      tick_hm_q         <= 1'b0;
      tick_fall_q       <= 1'b0;
      stretch_timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q   <= StRun;
            speed_q   <= bus.speed_sel;
            quarter_q <= Q0;
            cnt_q     <= '0;
            scl_oe_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        StRun: begin
          if (timeout_hit) begin
            state_q           <= StIdle;
            quarter_q         <= Q0;
            cnt_q             <= '0;
            scl_oe_q          <= 1'b0;
            busy_q            <= 1'b0;
            stretch_timeout_q <= 1'b1;
          end else if (cnt_adv) begin
            if (cnt_wrap) begin
              cnt_q <= '0;
              unique case (quarter_q)
                Q0: begin
                  quarter_q <= Q1;
                  tick_lm_q <= 1'b1;
                end
                Q1: begin
                  quarter_q   <= Q2;
                  tick_rise_q <= 1'b1;
                  scl_oe_q    <= 1'b0;
                end
                Q2: begin
                  quarter_q <= Q3;
                  tick_hm_q <= 1'b1;
                end
                Q3: begin
                  quarter_q <= Q0;
                  if (bus.en) begin
                    tick_fall_q <= 1'b1;
                    scl_oe_q    <= 1'b1;
                  end else begin
                    // Stop leaves SCL released; no bit boundary is signalled.
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                  end
                end
              endcase
            end else begin
              cnt_q <= cnt_q + 11'd1;
            end
          end
        end
      endcase
    end
  end

  assign bus.scl_oe          = scl_oe_q;
  assign bus.tick_low_mid    = tick_lm_q;
  assign bus.tick_rise       = tick_rise_q;
  assign bus.tick_high_mid   = tick_hm_q;
  assign bus.tick_fall       = tick_fall_q;
  assign bus.busy            = busy_q;
  assign bus.speed_active    = speed_q;
  assign bus.stretching      = stretching;
  assign bus.stretch_timeout = stretch_timeout_q;

endmodule

// File: tb/tb_i2c_scl_sched.sv
// Self-checking bench for i2c_scl_sched: SCL looped back through the pad
// (optionally held low to emulate a stretching slave), outputs compared every
// cycle against a schedule computed from the bit-timing rules.
module tb_i2c_scl_sched;

  localparam int unsigned CLK_HZ = 50000000;
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  localparam int unsigned TB_STRETCH_MAX = 100;
  localparam int          LONG_STRETCH   = 60;
`else
  localparam int unsigned TB_STRETCH_MAX = 50000;
  localparam int          LONG_STRETCH   = 1000;
`endif

  logic clk;
  logic reset;
  logic hold;
  int   cyc;
  int   total;
  int   bad;
  int   xs[4];

  i2c_scl_sched_if bus ();

  i2c_scl_sched #(
    .CLK_FREQUENCY(CLK_HZ),
    .STRETCH_MAX  (TB_STRETCH_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Open-drain pad: line is low if we drive it or the emulated slave holds it.
  assign bus.scl_in = hold ? 1'b0 : ~bus.scl_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (oe,lm,rise,hm,fall,busy,spd[2],str,to)",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [9:0] pack(input logic oe, input logic lm, input logic ri,
                                      input logic hm, input logic fa, input logic bz,
                                      input logic [1:0] sp, input logic st, input logic to);
    return {oe, lm, ri, hm, fa, bz, sp, st, to};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.scl_oe, bus.tick_low_mid, bus.tick_rise, bus.tick_high_mid, bus.tick_fall,
            bus.busy, bus.speed_active, bus.stretching, bus.stretch_timeout};
  endfunction

  function automatic int ref_qcnt(input logic [1:0] spd);
    int rate;
    rate = (spd == 2'd0) ? 10000 : (spd == 2'd2) ? 400000 : 100000;
    return CLK_HZ / (4 * rate);
  endfunction

  // One train of nbits bits; xs[i] = extra low cycles after tick_rise of bit i.
  // en drops drop_off cycles into the last bit, when speed_sel becomes late_sel.
  task automatic run_train(input logic [1:0] spd, input int nbits, input int drop_off,
                           input logic [1:0] late_sel);
    int q, s, b, fin;
    int bs[4], rs[4], hs[4];
    logic oe, lm, ri, hm, fa, bz, st;
    @(negedge clk);
    bus.speed_sel = spd;
    bus.en        = 1'b1;
    s = cyc + 1;
    q = ref_qcnt(spd);
    b = s;
    for (int i = 0; i < nbits; i++) begin
      bs[i] = b;
      rs[i] = b + 2 * q;
      hs[i] = rs[i] + q + 2 + xs[i];
      b     = hs[i] + q;
    end
    fin = b;
    for (int n = s; n <= fin + 3; n++) begin
      @(negedge clk);
      oe = 0; lm = 0; ri = 0; hm = 0; fa = 0; st = 0;
      bz = (n >= s) && (n < fin);
      hold = 1'b0;
      for (int i = 0; i < nbits; i++) begin
        if (n >= bs[i] && n < rs[i]) oe = 1;
        if (n == bs[i] + q) lm = 1;
        if (n == rs[i]) ri = 1;
        if (n >= rs[i] && n <= rs[i] + 1 + xs[i]) st = 1;
        if (n == hs[i]) hm = 1;
        if (i > 0 && n == bs[i]) fa = 1;
        if (n >= rs[i] && n < rs[i] + xs[i]) hold = 1'b1;
      end
      check("train", obs(), pack(oe, lm, ri, hm, fa, bz, spd, st, 1'b0));
      if (n == bs[nbits-1] + drop_off) begin
        bus.en        = 1'b0;
        bus.speed_sel = late_sel;
      end
      if (bad > 30) break;
    end
    hold   = 1'b0;
    bus.en = 1'b0;
  endtask

  initial begin
    int s, q, nb, x;
    logic [1:0] spd;
    reset         = 1'b1;
    hold          = 1'b0;
    bus.en        = 1'b0;
    bus.speed_sel = 2'd1;
    total         = 0;
    bad           = 0;
    xs            = '{default: 0};
    repeat (3) @(negedge clk);
    check("rst", obs(), pack(0, 0, 0, 0, 0, 0, 2'd1, 0, 0));
    reset = 1'b0;
    @(negedge clk);
    check("idle", obs(), pack(0, 0, 0, 0, 0, 0, 2'd1, 0, 0));

    // 100 kHz, two bits, period 502.
    run_train(2'd1, 2, 10, 2'd1);
    // 400 kHz, three bits, period 126.
    run_train(2'd2, 3, 5, 2'd2);
    // Long slave stretch on a single bit.
    xs[0] = LONG_STRETCH;
    run_train(2'd1, 1, 20, 2'd1);
    xs[0] = 0;
    // en dropped in Q1 with speed_sel changed: bit completes at the old rate.
    run_train(2'd1, 1, 125 + 10, 2'd0);

    // Reset in Q2 releases everything on the next edge, then a clean restart.
    @(negedge clk);
    bus.speed_sel = 2'd2;
    bus.en        = 1'b1;
    s = cyc + 1;
    while (cyc < s + 2 * 31 + 5) @(negedge clk);
    check("pre_rst_q2", obs(), pack(0, 0, 0, 0, 0, 1, 2'd2, 0, 0));
    reset  = 1'b1;
    bus.en = 1'b0;
    @(negedge clk);
    check("rst_q2", obs(), pack(0, 0, 0, 0, 0, 0, 2'd1, 0, 0));
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", obs(), pack(0, 0, 0, 0, 0, 0, 2'd1, 0, 0));
    run_train(2'd2, 2, 0, 2'd3);

    // 10 kHz, en dropped on the last cycle before the stop edge.
    run_train(2'd0, 1, 4 * 1250 + 1, 2'd3);

    // Randomized trains.
    for (int t = 0; t < 10 && bad <= 30; t++) begin
      spd = 2'($urandom_range(1, 3));
      nb  = $urandom_range(1, 3);
      q   = ref_qcnt(spd);
      for (int i = 0; i < 4; i++) xs[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : 0;
      x = xs[nb-1];
      run_train(spd, nb, $urandom_range(0, 4 * q + 1 + x), 2'($urandom_range(0, 3)));
    end
    xs = '{default: 0};

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
    // Slave holds SCL low forever: abort after TB_STRETCH_MAX stretching cycles.
    @(negedge clk);
    bus.speed_sel = 2'd2;
    bus.en        = 1'b1;
    s = cyc + 1;
    while (cyc < s + 2 * 31) @(negedge clk);
    hold = 1'b1;
    while (cyc < s + 2 * 31 + 99) @(negedge clk);
    check("to_pre", obs(), pack(0, 0, 0, 0, 0, 1, 2'd2, 1, 0));
    bus.en = 1'b0;
    @(negedge clk);
    check("to_hit", obs(), pack(0, 0, 0, 0, 0, 0, 2'd2, 0, 1));
    hold = 1'b0;
    @(negedge clk);
    check("to_after", obs(), pack(0, 0, 0, 0, 0, 0, 2'd2, 0, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
